// File: rtl/ddr100_rd_cal.sv
// ddr100_rd_cal -- read-capture calibration controller for one DDR100 DQ lane.
//
// On an accepted cal_start the block walks the one-hot capture select rsel
// across all NSEL positions. At each position it waits SETTLE cycles for the
// capture window pipeline to refill. It then issues TRIES known-pattern reads
// and compares every returned {p1,p0} beat against PATTERN. The per-position
// results go into pass_map. Finally rsel is parked at the centre of the
// longest contiguous passing window, scanning from low to high index with no
// wrap-around. If nothing passed, rsel returns to its pre-calibration value
// and cal_fail is set.
//
// Ports:
//   clk100m    in   PHY core clock, rising edge
//   phy_rst_n  in   asynchronous active-low reset
//   cal_start  in   start pulse, ignored while cal_busy
//   cal_busy   out  calibration in progress
//   cal_done   out  one-cycle end-of-calibration pulse
//   cal_fail   out  sticky: last calibration found no passing position
//   rd_req     out  read request to the command sequencer
//   rd_ack     in   read request accepted
//   rd_valid   in   rdata_p0/rdata_p1 carry a beat this cycle
//   rdata_p0   in   captured read data, phase 0
//   rdata_p1   in   captured read data, phase 1
//   rsel       out  one-hot capture select to the DQ lane
//   pass_map   out  per-position pass result of the last calibration
//   sel_idx    out  binary index of the set rsel bit
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: rd_req is a level request. It stays high until the cycle in
// which rd_ack is sampled high, and it is low from the next cycle on. The
// requester never withdraws a request early, except on its own timeout. Data
// beats are accepted only in the DATA state, one beat per cycle with rd_valid
// high. The lane has no back-pressure.

module ddr100_rd_cal #(
  parameter int                 NSEL    = 12,
  parameter int                 BURST   = 4,
  parameter logic [2*BURST-1:0] PATTERN = 8'b0110_1001,
  parameter int                 TRIES   = 2,
  parameter int                 SETTLE  = 3,
  parameter int                 TMO     = 255
) (
  input  logic            clk100m,
  input  logic            phy_rst_n,
  input  logic            cal_start,
  output logic            cal_busy,
  output logic            cal_done,
  output logic            cal_fail,
  output logic            rd_req,
  input  logic            rd_ack,
  input  logic            rd_valid,
  input  logic            rdata_p0,
  input  logic            rdata_p1,
  output logic [NSEL-1:0] rsel,
  output logic [NSEL-1:0] pass_map,
  output logic [3:0]      sel_idx,
  output logic [3:0]      dbg_state
);

  localparam int IW = 4;
  localparam int PW = IW + 1;
  localparam int TW = $clog2(TMO + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int KW = $clog2(BURST);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int RW = $clog2(TRIES + 1);

  localparam logic [IW-1:0] RST_IDX     = IW'(6);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NSEL - 1);
  localparam logic [PW-1:0] PICK_END    = PW'(NSEL);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TMO - 1);
  localparam logic [BW-1:0] BEAT_LAST   = BW'(BURST - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [RW-1:0] TRY_LAST    = RW'(TRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_WAIT, S_REQ, S_DATA, S_EVAL, S_NEXT, S_PICK, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [NSEL-1:0] prev_sel;
  logic [IW-1:0]   prev_idx;
  logic [RW-1:0]   try_cnt;
  logic            err;
  logic [SW-1:0]   wait_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [BW-1:0]   beat_cnt;
  logic [PW-1:0]   pick_i;
  logic [IW-1:0]   run_start, run_len, best_start, best_len;

  logic [1:0]      beat_exp;
  logic            tmo_last, data_last, pick_bit;
  logic [IW-1:0]   cur_start, cur_len, centre;

  function automatic logic [NSEL-1:0] onehot(input logic [IW-1:0] i);
    return {{(NSEL-1){1'b0}}, 1'b1} << i;
  endfunction

  always_comb begin
    beat_exp  = PATTERN[{beat_cnt[KW-1:0], 1'b0} +: 2];
    tmo_last  = (tmo_cnt == TMO_LAST);
    data_last = rd_valid && (beat_cnt == BEAT_LAST);
    pick_bit  = pass_map[pick_i[IW-1:0]];
    // A run starts at the current scan position when no run is open.
    cur_start = (run_len == '0) ? pick_i[IW-1:0] : run_start;
    cur_len   = run_len + IW'(1);
    centre    = best_start + ((best_len - IW'(1)) >> 1);
  end

  // State register.
  always_ff @(posedge clk100m or negedge phy_rst_n) begin
    if (!phy_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    cal_busy  = 1'b1;
    cal_done  = 1'b0;
    case (state)
      S_IDLE: begin
        cal_busy = 1'b0;
        if (cal_start) state_nxt = S_SET;
      end
      S_SET:  state_nxt = S_WAIT;
      S_WAIT: if (wait_cnt == SETTLE_LAST) state_nxt = S_REQ;
      S_REQ: begin
        rd_req = 1'b1;
        if (rd_ack)        state_nxt = S_DATA;
        else if (tmo_last) state_nxt = S_EVAL;
      end
      S_DATA: if (data_last || tmo_last) state_nxt = S_EVAL;
      S_EVAL: begin
        if (err || try_cnt == TRY_LAST) state_nxt = S_NEXT;
        else                            state_nxt = S_WAIT;
      end
      S_NEXT: state_nxt = (idx == IDX_LAST) ? S_PICK : S_SET;
      S_PICK: if (pick_i == PICK_END) state_nxt = S_DONE;
      S_DONE: begin
        cal_busy  = 1'b0;
        cal_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Datapath: select, counters, pass map and window search.
  always_ff @(posedge clk100m or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      rsel       <= onehot(RST_IDX);
      sel_idx    <= RST_IDX;
      pass_map   <= '0;
      cal_fail   <= 1'b0;
      idx        <= '0;
      prev_sel   <= '0;
      prev_idx   <= '0;
      try_cnt    <= '0;
      err        <= 1'b0;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      beat_cnt   <= '0;
      pick_i     <= '0;
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cal_start) begin
            prev_sel <= rsel;
            prev_idx <= sel_idx;
            pass_map <= '0;
            cal_fail <= 1'b0;
            idx      <= '0;
          end
        end
        S_SET: begin
          rsel     <= onehot(idx);
          sel_idx  <= idx;
          try_cnt  <= '0;
          err      <= 1'b0;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + SW'(1);
          tmo_cnt  <= '0;
        end
        S_REQ: begin
          tmo_cnt  <= tmo_cnt + TW'(1);
          beat_cnt <= '0;
          if (!rd_ack && tmo_last) err <= 1'b1;
        end
        S_DATA: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (rd_valid) begin
            beat_cnt <= beat_cnt + BW'(1);
            if ({rdata_p1, rdata_p0} != beat_exp) err <= 1'b1;
          end
          // The timeout only counts when the burst did not complete this cycle.
          if (tmo_last && !data_last) err <= 1'b1;
        end
        S_EVAL: begin
          wait_cnt <= '0;
          if (err) begin
            pass_map[idx] <= 1'b0;
          end else begin
            try_cnt <= try_cnt + RW'(1);
            if (try_cnt == TRY_LAST) pass_map[idx] <= 1'b1;
          end
        end
        S_NEXT: begin
          if (idx != IDX_LAST) idx <= idx + IW'(1);
          pick_i     <= '0;
          run_start  <= '0;
          run_len    <= '0;
          best_start <= '0;
          best_len   <= '0;
        end
        S_PICK: begin
          if (pick_i != PICK_END) begin
            pick_i <= pick_i + PW'(1);
            if (pick_bit) begin
              run_start <= cur_start;
              run_len   <= cur_len;
              // Strictly longer only, so the earliest of equal runs wins.
              if (cur_len > best_len) begin
                best_start <= cur_start;
                best_len   <= cur_len;
              end
            end else begin
              run_len <= '0;
            end
          end else if (best_len != '0) begin
            rsel    <= onehot(centre);
            sel_idx <= centre;
          end else begin
            cal_fail <= 1'b1;
            rsel     <= prev_sel;
            sel_idx  <= prev_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
